whack_a_mole_fsm: RTL and testbench

WHACK_A_MOLE_FSM -- requirements
Module: whack_a_mole_fsm

---
 rtl/whack_a_mole_fsm.sv | 134 +++++++++++++
 tb/tb_whack_a_mole_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/whack_a_mole_fsm.sv
// Purpose : game-control FSM for whack-a-mole; sequences IDLE/PLAYING/GAME_OVER/RESET and
//           produces the mole-up window and a per-period mole clock pulse from ms ticks.
// Latency : all outputs registered; one clk from input sample to output change.
// Backpr. : none; inputs are level/pulse sampled every cycle, outputs are free-running.
//
// Ports:
//   clk                  rising-edge system clock
//   rst_n                synchronous active-low reset
//   timer_milliseconds   game time remaining (ms), decremented externally once per ms
//   reset_button_pressed request to reset the game (highest priority after rst_n)
//   start_button_pressed request to start a game (ignored while playing or with timer == 0)
//   rst                  one-cycle reset pulse to downstream blocks (high in RESET)
//   game_in_progress     high while in PLAYING
//   mole_clk             one-cycle pulse at the start of each mole-up window
//   mole_up_window       high while the mole is up
//   dbg_state            current state: IDLE=0 PLAYING=1 GAME_OVER=2 RESET=3
module whack_a_mole_fsm #(
    parameter int MOLE_UP_MS   = 7,
    parameter int MOLE_DOWN_MS = 5,
    parameter int MAX_TIMER_MS = 200,
    localparam int PERIOD      = MOLE_UP_MS + MOLE_DOWN_MS,
    localparam int TMW         = $clog2(MAX_TIMER_MS + 1),
    localparam int PHW         = ($clog2(PERIOD) < 1) ? 1 : $clog2(PERIOD)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [TMW-1:0] timer_milliseconds,
    input  logic           reset_button_pressed,
    input  logic           start_button_pressed,
    output logic           rst,
    output logic           game_in_progress,
    output logic           mole_clk,
    output logic           mole_up_window,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PLAYING   = 2'd1,
        S_GAME_OVER = 2'd2,
        S_RESET     = 2'd3
    } state_t;

    // Phase counts down from PH_TOP; the upper MOLE_UP_MS values are the "up" part.
    localparam logic [PHW-1:0] PH_TOP  = PHW'(PERIOD - 1);
    localparam logic [PHW-1:0] PH_DOWN = PHW'(MOLE_DOWN_MS);

    state_t         state;
    logic [PHW-1:0] phase;
    logic [PHW-1:0] phase_dec;
    logic [TMW-1:0] timer_prev;
    logic           tick;
    logic           timer_zero;

    // A tick is any change of the externally decremented timer, so the block
    // needs no knowledge of the clk-to-ms ratio.
    assign tick       = (timer_milliseconds != timer_prev);
    assign timer_zero = (timer_milliseconds == '0);
    assign phase_dec  = phase - PHW'(1);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_RESET;
            rst              <= 1'b1;
            game_in_progress <= 1'b0;
            mole_clk         <= 1'b0;
            mole_up_window   <= 1'b0;
            phase            <= PH_TOP;
            timer_prev       <= timer_milliseconds;
        end else begin
            timer_prev <= timer_milliseconds;
            mole_clk   <= 1'b0;

            if (reset_button_pressed) begin
                state            <= S_RESET;
                rst              <= 1'b1;
                game_in_progress <= 1'b0;
                mole_up_window   <= 1'b0;
                phase            <= PH_TOP;
            end else begin
                case (state)
                    S_RESET: begin
                        state            <= S_IDLE;
                        rst              <= 1'b0;
                        game_in_progress <= 1'b0;
                        mole_up_window   <= 1'b0;
                    end

                    S_IDLE, S_GAME_OVER: begin
                        rst            <= 1'b0;
                        mole_up_window <= 1'b0;
                        // A start wins over a coincident tick: phase restarts at the top.
                        if (start_button_pressed && !timer_zero) begin
                            state            <= S_PLAYING;
                            game_in_progress <= 1'b1;
                            phase            <= PH_TOP;
                            mole_clk         <= 1'b1;
                            mole_up_window   <= (PH_TOP >= PH_DOWN);
                        end else begin
                            game_in_progress <= 1'b0;
                        end
                    end

                    S_PLAYING: begin
                        rst <= 1'b0;
                        if (timer_zero) begin
                            state            <= S_GAME_OVER;
                            game_in_progress <= 1'b0;
                            mole_up_window   <= 1'b0;
                        end else if (tick) begin
                            if (phase == '0) begin
                                phase          <= PH_TOP;
                                mole_clk       <= 1'b1;
                                mole_up_window <= (PH_TOP >= PH_DOWN);
                            end else begin
                                phase          <= phase_dec;
                                mole_up_window <= (phase_dec >= PH_DOWN);
                            end
                        end
                    end

                    default: begin
                        state            <= S_IDLE;
                        rst              <= 1'b0;
                        game_in_progress <= 1'b0;
                        mole_up_window   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_whack_a_mole_fsm.sv
module tb_whack_a_mole_fsm;

    localparam int UP_MS   = 7;
    localparam int DOWN_MS = 5;
    localparam int PER     = UP_MS + DOWN_MS;

    logic       clk;
    logic       rst_n;
    logic [7:0] timer;
    logic       reset_button;
    logic       start_button;
    logic       rst;
    logic       game_in_progress;
    logic       mole_clk;
    logic       mole_up_window;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    whack_a_mole_fsm dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .timer_milliseconds   (timer),
        .reset_button_pressed (reset_button),
        .start_button_pressed (start_button),
        .rst                  (rst),
        .game_in_progress     (game_in_progress),
        .mole_clk             (mole_clk),
        .mole_up_window       (mole_up_window),
        .dbg_state            (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the game as "ticks elapsed since the game started"; the mole is up
    // for the first UP_MS ticks of every PER-tick period.
    int m_state = 0;     // 0 idle, 1 playing, 2 game over, 3 reset
    int m_ticks = 0;
    bit m_clk   = 0;
    int m_prev  = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        bit t;
        m_clk = 0;
        if (!rst_n) begin
            m_state = 3;
            m_ticks = 0;
            m_prev  = int'(timer);
            m_valid = 1;
        end else begin
            t      = (int'(timer) != m_prev);
            m_prev = int'(timer);
            if (reset_button)         m_state = 3;
            else if (m_state == 3)    m_state = 0;
            else if (m_state != 1) begin
                if (start_button && timer != 0) begin
                    m_state = 1;
                    m_ticks = 0;
                    m_clk   = 1;
                end
            end else if (timer == 0)  m_state = 2;
            else if (t) begin
                m_ticks++;
                if (m_ticks % PER == 0) m_clk = 1;
            end
        end
    end

    // Outputs change only on posedge; compare on every negedge once reset has been seen.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("rst",              32'(rst),              32'(m_state == 3));
            chk("game_in_progress", 32'(game_in_progress), 32'(m_state == 1));
            chk("mole_clk",         32'(mole_clk),         32'(m_clk));
            chk("mole_up_window",   32'(mole_up_window),
                32'(m_state == 1 && (m_ticks % PER) < UP_MS));
            chk("dbg_state",        32'(dbg_state),        32'(m_state));
        end
    end

    // One millisecond = 50 clocks; returns on the negedge after the tick is absorbed.
    task automatic tick_ms();
        repeat (49) @(negedge clk);
        timer = timer - 8'd1;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        rst_n        = 1'b0;
        timer        = 8'd0;
        reset_button = 1'b0;
        start_button = 1'b0;

        // Reset held two cycles, then released.
        repeat (2) @(negedge clk);
        chk("lit_reset_rst", 32'(rst), 32'd1);
        chk("lit_reset_state", 32'(dbg_state), 32'd3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("lit_idle_state", 32'(dbg_state), 32'd0);
        chk("lit_idle_rst", 32'(rst), 32'd0);

        // Start a game with 20 ms on the clock.
        timer = 8'd20;
        @(negedge clk);
        start_button = 1'b1;
        @(negedge clk);
        start_button = 1'b0;
        chk("lit_start_state", 32'(dbg_state), 32'd1);
        chk("lit_start_gip", 32'(game_in_progress), 32'd1);
        chk("lit_start_mclk", 32'(mole_clk), 32'd1);
        chk("lit_start_up", 32'(mole_up_window), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            tick_ms();
            chk("lit_up_pattern", 32'(mole_up_window), 32'((k % 12) < 7));
            chk("lit_mclk_pattern", 32'(mole_clk), 32'(k == 12));
        end

        // Run down to zero -> GAME_OVER, then no more mole pulses.
        while (timer != 8'd0) tick_ms();
        chk("lit_over_state", 32'(dbg_state), 32'd2);
        chk("lit_over_gip", 32'(game_in_progress), 32'd0);
        chk("lit_over_up", 32'(mole_up_window), 32'd0);
        pulses = 0;
        repeat (100) begin
            @(negedge clk);
            if (mole_clk) pulses++;
        end
        chk("lit_over_no_pulses", 32'(pulses), 32'd0);
        chk("lit_over_hold", 32'(dbg_state), 32'd2);

        // Restart from GAME_OVER with a fresh timer (tick coincides with start).
        timer        = 8'd30;
        start_button = 1'b1;
        @(negedge clk);
        start_button = 1'b0;
        chk("lit_restart_state", 32'(dbg_state), 32'd1);
        chk("lit_restart_mclk", 32'(mole_clk), 32'd1);
        chk("lit_restart_up", 32'(mole_up_window), 32'd1);

        // Reset button at the third tick of the game.
        tick_ms();
        tick_ms();
        chk("lit_t2_up", 32'(mole_up_window), 32'd1);
        repeat (49) @(negedge clk);
        timer        = timer - 8'd1;
        reset_button = 1'b1;
        @(negedge clk);
        reset_button = 1'b0;
        chk("lit_rb_rst", 32'(rst), 32'd1);
        chk("lit_rb_state", 32'(dbg_state), 32'd3);
        chk("lit_rb_gip", 32'(game_in_progress), 32'd0);
        @(negedge clk);
        chk("lit_rb_idle", 32'(dbg_state), 32'd0);
        chk("lit_rb_rst_low", 32'(rst), 32'd0);

        // Start with timer == 0 is ignored.
        timer = 8'd0;
        @(negedge clk);
        start_button = 1'b1;
        @(negedge clk);
        start_button = 1'b0;
        chk("lit_zero_start", 32'(dbg_state), 32'd0);

        // Start while playing does not reload the phase.
        timer        = 8'd40;
        start_button = 1'b1;
        @(negedge clk);
        start_button = 1'b0;
        chk("lit_play2_state", 32'(dbg_state), 32'd1);
        tick_ms();
        tick_ms();
        start_button = 1'b1;
        @(negedge clk);
        start_button = 1'b0;
        chk("lit_restart_ignored_mclk", 32'(mole_clk), 32'd0);
        repeat (4) tick_ms();
        chk("lit_t6_up", 32'(mole_up_window), 32'd1);
        tick_ms();
        chk("lit_t7_down", 32'(mole_up_window), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            rst_n        = ($urandom_range(999, 0) != 0);
            reset_button = ($urandom_range(199, 0) == 0);
            start_button = ($urandom_range(39, 0) == 0);
            if ($urandom_range(299, 0) == 0)
                timer = 8'($urandom_range(200, 0));
            else if (timer != 8'd0 && $urandom_range(14, 0) == 0)
                timer = timer - 8'd1;
        end
        rst_n        = 1'b1;
        reset_button = 1'b0;
        start_button = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
